register_dump_tx: RTL
=====================

// Module: register_dump_tx
// PURPOSE
//  Serialises a snapshot of the 32-entry register file onto the UART transmit path for debug.
//  On a start pulse it sends one header byte, then walks the register file from address 0 upward.
//  Each register is read through the file's synchronous read port and sent as 4 bytes, MSB first.
//  Sits between the ID-stage register file (read side) and the UART transmitter (valid/ready byte sink).
// PARAMETERS
//  NUM_REGS     32     registers dumped, addresses 0..NUM_REGS-1
//  ADDR_WIDTH   5      width of reg_addr; 2**ADDR_WIDTH >= NUM_REGS
//  DATA_WIDTH   32     register width; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
//  HEADER_BYTE  8'hA5  frame marker sent before register 0
// PORTS
//  clock     in   1           system clock, all state on posedge
//  reset     in   1           asynchronous, active-high; returns block to IDLE
//  start     in   1           dump request, sampled on posedge; ignored unless in IDLE
//  reg_addr  out  ADDR_WIDTH  register file read address
//  reg_data  in   DATA_WIDTH  register file read data, valid 1 cycle after reg_addr (registered read)
//  tx_data   out  8           byte to UART transmitter
//  tx_valid  out  1           tx_data valid; byte transfers on posedge with tx_valid && tx_ready
//  tx_ready  in   1           UART transmitter can accept a byte
//  busy      out  1           high from the cycle after start is accepted until DONE completes
//  done      out  1           one-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset: state=IDLE, reg_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, idx=0, byte_cnt=0, shift=0.
//  Reset is asynchronous: tx_valid, busy and done fall immediately, mid-byte or otherwise.
//  No partial-frame resume after reset; a new start sends a full frame.
//  States and transitions:
//   IDLE:   busy=0. If start, go to HEADER and clear idx.
//   HEADER: tx_valid=1, tx_data=HEADER_BYTE. On handshake, go to FETCH.
//   FETCH:  reg_addr=idx (held constant through LATCH). Go to LATCH.
//   LATCH:  shift<=reg_data, byte_cnt<=0. Go to SEND.
//   SEND:   tx_valid=1, tx_data=shift[DATA_WIDTH-1 -: 8].
//           On handshake, shift left by 8 and increment byte_cnt.
//           On handshake with byte_cnt==BYTES-1: if idx==NUM_REGS-1 go to DONE, else idx++ and go to FETCH.
//   DONE:   done=1 for exactly one cycle, busy=1. Go to IDLE.
//  Handshake rules:
//   - Once tx_valid is high, tx_valid and tx_data hold stable until the accepting edge.
//   - Never drop a byte; never duplicate a byte.
//   - tx_valid is low in IDLE, FETCH, LATCH and DONE. It never depends combinationally on tx_ready.
//  Snapshot semantics: each register is captured in its LATCH cycle.
//   - Writes to a register before its fetch are reflected in the dump.
//   - Writes after its capture are not.
//  Frame and timing:
//   - Frame = 1 + NUM_REGS*BYTES bytes (129 with defaults).
//   - With tx_ready held high: header is accepted in cycle 1 after start, then 6 cycles per register.
//   - Under that condition, done asserts 1+6*NUM_REGS+1 = 194 cycles after the start edge.
//  Boundary conditions:
//   - start while busy (HEADER..DONE) is ignored.
//   - start high in the DONE cycle is ignored.
//   - start held high continuously gives back-to-back frames separated by exactly one IDLE cycle.
//   - idx does not wrap; termination is by compare against NUM_REGS-1.
//   - reg_addr stays at the last address after the frame.
//   - tx_ready low for any length stalls only in HEADER or SEND; no timeout.
// TESTING
//  1. Default register init (r1=10, r3=15, r5=-5, r6=12, r15=5, others 0), tx_ready=1, start pulse ->
//     stream A5, 00000000, 0000000A, 00000000, 0000000F, 00000000, FFFFFFFB, 0000000C, ...,
//     r15=00000005, remaining 0; 129 bytes total; done once at cycle 194.
//  2. tx_ready pseudo-random 50%, plus held low 20 cycles in mid-register ->
//     tx_valid/tx_data stable while stalled; same 129-byte stream as test 1; no loss or duplication.
//  3. Start pulses at cycles 5, 40 and in the DONE cycle -> exactly one frame; busy contiguous.
//  4. Assert reset asynchronously after the 50th byte, mid-SEND ->
//     tx_valid/busy low before the next edge; a later start yields a complete fresh frame beginning A5.
//  5. Write r20=32'hDEADBEEF while idx<20, then r1=32'h12345678 after r1 is captured ->
//     dump shows DE AD BE EF for r20 and 00 00 00 0A for r1.
//  6. start tied high, tx_ready=1 -> consecutive frames, one IDLE cycle between done and the next A5 header.

Source files
------------

// File: rtl/register_dump_tx.sv
// register_dump_tx
// Serialises a snapshot of the register file onto a valid/ready byte sink
// (UART transmitter) for debug. A start request in IDLE sends HEADER_BYTE,
// then each register from address 0 upward as BYTES bytes, MSB first.
// Every register is read through the file's synchronous read port and
// captured in its LATCH cycle.
//
// Ports
//   clock_i     system clock, all state on posedge
//   reset_i     asynchronous active-high reset, returns the block to IDLE
//   start_i     dump request, only honoured in IDLE
//   reg_addr_o  register file read address (data returns one cycle later)
//   reg_data_i  register file read data
//   tx_data_o   byte to the UART transmitter
//   tx_valid_o  tx_data_o valid; a byte moves on posedge with valid && ready
//   tx_ready_i  transmitter can accept a byte
//   busy_o      high from the cycle after start is accepted until DONE ends
//   done_o      one-cycle pulse after the final byte is accepted
module register_dump_tx #(
  parameter int          NUM_REGS    = 32,
  parameter int          ADDR_WIDTH  = 5,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    LATCH,
    SEND,
    DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  busy_q;
  logic                  done_q;

  // Shift register contents after the current byte has been accepted.
  always_comb begin
    shift_d = shift_q << 8;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      reg_addr_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= HEADER;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER_BYTE;
          end
        end

        HEADER: begin
          if (tx_ready_i) begin
            state_q    <= FETCH;
            tx_valid_q <= 1'b0;
            // Address presented on entry to FETCH so the registered read
            // returns data during LATCH.
            reg_addr_q <= idx_q;
          end
        end

        FETCH: begin
          state_q <= LATCH;
        end

        LATCH: begin
          // Snapshot point for this register.
          shift_q    <= reg_data_i;
          byte_cnt_q <= '0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= reg_data_i[DATA_WIDTH-1 -: 8];
          state_q    <= SEND;
        end

        SEND: begin
          if (tx_ready_i) begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              if (idx_q == LAST_REG) begin
                // reg_addr stays at the final address after the frame.
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q      <= idx_q + 1'b1;
                reg_addr_q <= idx_q + 1'b1;
                state_q    <= FETCH;
              end
            end else begin
              tx_data_q <= shift_d[DATA_WIDTH-1 -: 8];
            end
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign reg_addr_o = reg_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
